// File: rtl/pckt_loopback_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pckt_loopback_fifo
// Description : Store-and-forward frame FIFO between the RX MAC AXI-Stream
//               output and the TX MAC input. Only complete, good frames are
//               forwarded. A frame is discarded if it is flagged bad (tuser on
//               tlast) or if it overflows the buffer.
//               Bytes are written speculatively behind a commit pointer. The
//               read side only ever sees bytes up to that commit pointer.
// Ports       : i_clk, i_reset          - clock, synchronous active-high reset
//               s_axis_*                - byte stream from the RX MAC; never
//                                         stalled once out of reset
//               m_axis_*                - byte stream to the TX MAC
//               o_frame_count           - frames committed since reset (wraps)
//               o_drop_count            - frames dropped since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pckt_loopback_fifo #(
    parameter int DEPTH     = 4096,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic                 s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] o_frame_count,
    output logic [CNT_WIDTH-1:0] o_drop_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;

    localparam logic [c_PTR_W-1:0]   c_DEPTH   = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_DROP  = 2'd2;

    // Each entry holds {last, data}.
    logic [8:0]           r_mem [0:DEPTH-1];

    logic [1:0]           r_state;
    logic [c_PTR_W-1:0]   r_wr_ptr_commit;
    logic [c_PTR_W-1:0]   r_wr_ptr_cur;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic                 r_s_ready;
    logic [7:0]           r_m_data;
    logic                 r_m_last;
    logic                 r_m_valid;
    logic [CNT_WIDTH-1:0] r_frame_count;
    logic [CNT_WIDTH-1:0] r_drop_count;

    logic [c_PTR_W-1:0]   w_used;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_mem_we;
    logic                 w_load;
    logic [8:0]           w_rd_word;

    // Occupancy counts speculative bytes too, so that a frame in progress
    // cannot overwrite committed data that has not been read yet.
    assign w_used    = r_wr_ptr_cur - r_rd_ptr;
    assign w_full    = (w_used == c_DEPTH);
    assign w_empty   = (r_rd_ptr == r_wr_ptr_commit);
    assign w_accept  = s_axis_tvalid && r_s_ready;
    assign w_mem_we  = w_accept && !w_full && (r_state != c_DROP);
    assign w_load    = (!r_m_valid || m_axis_tready) && !w_empty;
    assign w_rd_word = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    // ------------------------------------------------------------------
    // Storage: no reset. Contents past the commit pointer are never read.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr_cur[c_ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // ------------------------------------------------------------------
    // Write side: speculative write, then commit or roll back on tlast
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= c_IDLE;
            r_wr_ptr_commit <= '0;
            r_wr_ptr_cur    <= '0;
            r_s_ready       <= 1'b0;
            r_frame_count   <= '0;
            r_drop_count    <= '0;
        end else begin
            r_s_ready <= 1'b1;
            if (w_accept) begin
                case (r_state)
                    c_IDLE, c_WRITE: begin
                        if (s_axis_tlast) begin
                            r_state <= c_IDLE;
                            if (w_full || s_axis_tuser) begin
                                // Bad frame, or overflow on the final beat.
                                r_wr_ptr_cur <= r_wr_ptr_commit;
                                r_drop_count <= r_drop_count + c_CNT_ONE;
                            end else begin
                                r_wr_ptr_cur    <= r_wr_ptr_cur + c_PTR_ONE;
                                r_wr_ptr_commit <= r_wr_ptr_cur + c_PTR_ONE;
                                r_frame_count   <= r_frame_count + c_CNT_ONE;
                            end
                        end else if (w_full) begin
                            r_state <= c_DROP;
                        end else begin
                            r_wr_ptr_cur <= r_wr_ptr_cur + c_PTR_ONE;
                            r_state      <= c_WRITE;
                        end
                    end
                    default: begin
                        // Dropping: swallow beats until the end of the frame.
                        if (s_axis_tlast) begin
                            r_wr_ptr_cur <= r_wr_ptr_commit;
                            r_drop_count <= r_drop_count + c_CNT_ONE;
                            r_state      <= c_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: single output register fed from committed bytes only
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= 8'h00;
            r_m_last  <= 1'b0;
        end else if (w_load) begin
            r_m_data  <= w_rd_word[7:0];
            r_m_last  <= w_rd_word[8];
            r_m_valid <= 1'b1;
            r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign o_frame_count = r_frame_count;
    assign o_drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pckt_loopback_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pckt_loopback_fifo
// Description : Self-checking bench for pckt_loopback_fifo. The reference is
//               a byte queue holding every byte of every frame that must be
//               forwarded. The bench also keeps expected frame and drop
//               counts. Randomized frames and a randomized TX ready are
//               checked against it on every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pckt_loopback_fifo;

    localparam int DEPTH = 2048;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_axis_tdata  = 8'h00;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast  = 1'b0;
    logic          s_axis_tuser  = 1'b0;
    logic          s_axis_tready;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;

    pckt_loopback_fifo #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .o_frame_count (frame_count),
        .o_drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: bytes {last,data} still owed to the TX side, in order.
    logic [8:0]    exp_q[$];
    logic [CW-1:0] exp_frames = '0;
    logic [CW-1:0] exp_drops  = '0;
    int            checks = 0;
    int            errors = 0;
    int            ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // TX ready driver
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output compare: every valid cycle must present the model's head byte.
    initial begin
        logic [8:0] popped;
        forever begin
            @(negedge clk);
            if (!rst && m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got valid byte 0x%0h last %0b, required no output",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    chk("out_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_q[0]));
                    if (m_axis_tready) popped = exp_q.pop_front();
                end
            end
        end
    end

    // Sends one frame; base < 0 gives random bytes, otherwise base+i.
    // Returns at the falling edge of the cycle after the tlast beat, after
    // checking that the counters have already moved.
    task automatic send_frame(input int len, input bit bad, input int base);
        logic [8:0] words[$];
        int         budget;
        bit         ok;
        logic [7:0] d;
        ok = !bad && (len <= DEPTH);
        sync();
        budget = 100;
        while (!s_axis_tready && budget > 0) begin
            sync();
            budget--;
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: s_axis_tready got 0, required 1");
        end
        // Only start a frame that fits alongside the bytes still owed.
        budget = 20000;
        while (len <= DEPTH && exp_q.size() + len > DEPTH && budget > 0) begin
            sync();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL room_wait: got %0d bytes still queued, required room for %0d", exp_q.size(), len);
        end
        for (int i = 0; i < len; i++) begin
            d = (base < 0) ? 8'($urandom) : 8'(base + i);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
            words.push_back({s_axis_tlast, d});
            sync();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (ok) begin
            foreach (words[k]) exp_q.push_back(words[k]);
            exp_frames++;
        end else begin
            exp_drops++;
        end
        @(negedge clk);
        chk("frame_count", 32'(frame_count), 32'(exp_frames));
        chk("drop_count", 32'(drop_count), 32'(exp_drops));
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 20000;
        sync();
        while (exp_q.size() > 0 && budget > 0) begin
            sync();
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d bytes undelivered, required 0", name, exp_q.size());
        end
        sync();
        sync();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation got past the time limit, required finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int n;
        int len;
        bit bad;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_data", 32'(m_axis_tdata), 32'd0);
        chk("rst_m_last", 32'(m_axis_tlast), 32'd0);
        chk("rst_frames", 32'(frame_count), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        sync();
        rst = 1'b0;
        sync();
        @(negedge clk);
        chk("ready_after_rst", 32'(s_axis_tready), 32'd1);

        // 1: 64-byte good frame, latency N+2, literal head byte
        ready_mode = 1;
        send_frame(64, 1'b0, 8'h10);
        chk("t1_valid_n1", 32'(m_axis_tvalid), 32'd0);
        chk("t1_frames_lit", 32'(frame_count), 32'd1);
        chk("t1_drops_lit", 32'(drop_count), 32'd0);
        @(negedge clk);
        chk("t1_valid_n2", 32'(m_axis_tvalid), 32'd1);
        chk("t1_byte0_lit", 32'(m_axis_tdata), 32'h10);
        wait_drain("t1_drain");

        // 2: bad 100-byte frame, then good 60-byte frame
        send_frame(100, 1'b1, -1);
        send_frame(60, 1'b0, -1);
        wait_drain("t2_drain");
        chk("t2_frames_lit", 32'(frame_count), 32'd2);
        chk("t2_drops_lit", 32'(drop_count), 32'd1);

        // 3: capacity boundary with TX stalled
        ready_mode = 0;
        send_frame(DEPTH, 1'b0, -1);
        ready_mode = 1;
        wait_drain("t3_full_drain");
        ready_mode = 0;
        send_frame(DEPTH + 1, 1'b0, -1);
        chk("t3_drop_lit", 32'(drop_count), 32'd2);
        send_frame(DEPTH + 3, 1'b0, -1);
        chk("t3_idle_after_drop", 32'(m_axis_tvalid), 32'd0);
        ready_mode = 1;
        send_frame(40, 1'b0, -1);
        wait_drain("t3_after_drop");

        // Back-to-back committed frames drain with no bubble
        ready_mode = 0;
        send_frame(30, 1'b0, -1);
        send_frame(50, 1'b0, -1);
        sync();
        ready_mode = 1;
        n = 0;
        repeat (80) begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) n++;
        end
        chk("throughput_beats", 32'(n), 32'd80);
        @(negedge clk);
        chk("throughput_end", 32'(m_axis_tvalid), 32'd0);

        // 4: single-byte frame
        send_frame(1, 1'b0, 8'hA5);
        chk("t4_valid_n1", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        chk("t4_valid_n2", 32'(m_axis_tvalid), 32'd1);
        chk("t4_data_lit", 32'(m_axis_tdata), 32'hA5);
        chk("t4_last_lit", 32'(m_axis_tlast), 32'd1);
        wait_drain("t4_drain");

        // 5: random stress with random TX ready
        ready_mode = 2;
        for (int f = 0; f < 50; f++) begin
            len = $urandom_range(60, 400);
            bad = (f == 7) || ($urandom_range(0, 99) < 5);
            send_frame(len, bad, -1);
            repeat ($urandom_range(0, 3)) sync();
        end
        send_frame(1500, 1'b0, -1);
        wait_drain("t5_drain");
        chk("t5_frames", 32'(frame_count), 32'(exp_frames));
        chk("t5_drops", 32'(drop_count), 32'(exp_drops));

        // 6: reset in the middle of an output frame
        ready_mode = 1;
        send_frame(64, 1'b0, 8'h40);
        n = 1000;
        sync();
        while (exp_q.size() > 32 && n > 0) begin
            sync();
            n--;
        end
        rst = 1'b1;
        exp_q.delete();
        exp_frames = '0;
        exp_drops  = '0;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid_cleared", 32'(m_axis_tvalid), 32'd0);
        chk("t6_frames_cleared", 32'(frame_count), 32'd0);
        chk("t6_drops_cleared", 32'(drop_count), 32'd0);
        chk("t6_ready_low", 32'(s_axis_tready), 32'd0);
        send_frame(64, 1'b0, -1);
        wait_drain("t6_drain");
        chk("t6_frames_lit", 32'(frame_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pckt_loopback_fifo.md
# pckt_loopback_fifo

Store-and-forward frame FIFO in the MAC top-level feedback path. Sits downstream of the RGMII RX MAC's AXI-Stream output and upstream of the TX MAC input. It forwards only complete, good frames: frames flagged bad by the RX MAC (`tuser` on `tlast`) are discarded, as are frames that overflow the buffer. The TX MAC therefore never sees a partial or corrupt frame and never underruns mid-frame.

## Interface

**Parameters**
- `DEPTH`, default 4096: buffer depth in bytes; must be a power of 2 and ≥ 16.
- `CNT_WIDTH`, default 16: width of the status counters.

**Ports**
- `i_clk`, in, 1: single clock for both sides.
- `i_reset`, in, 1: synchronous, active-high reset.
- `s_axis_tdata`, in, 8: RX MAC byte.
- `s_axis_tvalid`, in, 1: RX byte valid.
- `s_axis_tlast`, in, 1: last byte of frame.
- `s_axis_tuser`, in, 1: bad-frame flag (CRC/framing error). Sampled only with `tlast`.
- `s_axis_tready`, out, 1: upstream ready.
- `m_axis_tdata`, out, 8: byte to TX MAC.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tlast`, out, 1: last byte of forwarded frame.
- `m_axis_tready`, in, 1: TX MAC ready.
- `o_frame_count`, out, `CNT_WIDTH`: frames committed since reset; wraps.
- `o_drop_count`, out, `CNT_WIDTH`: frames dropped since reset; wraps.

## Operation

- **Storage:** memory of `DEPTH` × 9 bits, holding {last, data}. Pointers are log2(DEPTH)+1 bits wide.
- **Pointers:**
  - `wr_ptr_commit`: end of the last good frame.
  - `wr_ptr_cur`: speculative write position.
  - `rd_ptr`: read position.
- **Occupancy:** used = `wr_ptr_cur − rd_ptr`, modulo 2^(log2(DEPTH)+1).
  - Full when used == `DEPTH`.
  - Empty for read when `rd_ptr == wr_ptr_commit`.
- **Upstream ready:** `s_axis_tready` = 1 whenever out of reset. The RX MAC cannot be stalled; overflow is handled by dropping the frame.
- **Write FSM, states IDLE / WRITE / DROP:**
  - IDLE, accepted beat:
    - If not full: write the byte and increment `wr_ptr_cur`.
    - If `tlast` is also set: finalize the frame (see below) and stay in IDLE.
    - Otherwise go to WRITE.
  - WRITE, accepted beat:
    - If full: go to DROP and do not write the byte.
    - Else: write the byte and increment `wr_ptr_cur`.
    - On `tlast`: finalize the frame and go to IDLE.
  - DROP: discard all beats. On `tlast`, roll back (`wr_ptr_cur ← wr_ptr_commit`), increment `o_drop_count` and go to IDLE.
- **Finalize a frame:**
  - Good frame (`tuser` = 0, no overflow): `wr_ptr_commit ← wr_ptr_cur + 1` and `o_frame_count` increments. The stored last bit of that byte is 1.
  - Bad frame (`tuser` = 1): rollback as in DROP and `o_drop_count` increments.
- **Overflow on the `tlast` beat itself** (full in IDLE or WRITE with `tlast`): roll back and count a drop.
- **Read side:**
  - A single output register holds the head byte and is loaded from `mem[rd_ptr]`.
  - The register loads when (`!m_axis_tvalid` || `m_axis_tready`) and the FIFO is not empty; `rd_ptr` increments on each load.
  - The read side never reads past `wr_ptr_commit`. Uncommitted bytes are invisible to it.
- **Simultaneous events:**
  - A commit and a read in the same cycle are legal; each side updates its own pointer.
  - A rollback never moves `wr_ptr_cur` below `rd_ptr`.
  - Freed space is visible to the full check in the cycle after the read.

## Timing

- **Reset values:** all outputs 0, including `s_axis_tready`. FSM in IDLE, all pointers 0, counters 0.
- **After reset:** `s_axis_tready` = 1 from the first cycle after `i_reset` deasserts.
- **Resets mid-frame:**
  - Reset mid-output: the output register is cleared and any stored frames are lost.
  - Reset mid-input: the partial frame is discarded. Upstream shares `i_reset`, so no resync is needed.
- **Latency:** if the `tlast` beat of a good frame is accepted in cycle N (FIFO previously empty), `m_axis_tvalid` rises in cycle N+2 carrying byte 0.
- **Throughput:** with `m_axis_tready` held at 1, one byte per cycle with no bubbles, including across frame boundaries when the next frame is already committed.
- **Counter timing:** counters update in cycle N+1.
- **Output holding:** `m_axis_tdata`/`m_axis_tlast` are stable while `m_axis_tvalid` && !`m_axis_tready`.
- **Capacity:** a frame of exactly `DEPTH` bytes into an empty FIFO is committed. `DEPTH`+1 bytes is dropped.

## Test plan

1. **Good frame:** 64-byte good frame, `m_axis_tready` = 1 → identical 64 bytes out, `tlast` on byte 64, `tvalid` at N+2, `o_frame_count` = 1, `o_drop_count` = 0.
2. **Bad frame then good frame:** 100-byte frame with `tuser` = 1 on `tlast`, then a 60-byte good frame → only the 60-byte frame appears, `o_drop_count` = 1, `o_frame_count` = 1.
3. **Overflow boundary:** `DEPTH` = 64, `m_axis_tready` = 0:
   - 64-byte frame → committed.
   - Drain the FIFO, hold `m_axis_tready` = 0 again, send a 65-byte frame → dropped, `o_drop_count` = 1.
   - Next 40-byte frame passes intact.
4. **Single-byte frame:** one beat with `tlast` = 1, data 0xA5 → one output beat with 0xA5 and `tlast` = 1, `o_frame_count` = 1.
5. **Random stress:** 50 random frames of 60–1500 bytes, with 5% flagged bad and `m_axis_tready` randomized at 50% → output equals the good frames in order, byte-exact. Counters equal the number of good and bad frames.
6. **Reset mid-output:** assert `i_reset` for 1 cycle midway through a frame's output → next cycle `m_axis_tvalid` = 0 and counters = 0. The following 64-byte frame is forwarded correctly.
